hvac_seq: RTL
=============

# hvac_seq

Clocked sequencer for the heater and cooler actuators of the temperature-control path. It samples temperature against the low/high thresholds on a strobe and latches heat/cool demand. It drives `heat_out`/`cool_out` through a four-state FSM that enforces a minimum on-time and a minimum off-time (compressor/element lockout). Heating and cooling are never active together, and a direct heat↔cool switch is not possible.

## Interface
- `WIDTH`, 16: width of temperature and threshold operands, unsigned.
- `CNT_W`, 8: dwell-timer width.
- `MIN_ON`, 8: minimum cycles an actuator stays on; legal range 1..2^CNT_W-1.
- `MIN_OFF`, 8: lockout cycles after any actuator turns off; legal range 1..2^CNT_W-1.

Ports (name, direction, width, meaning):
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sample`  in  1  single-cycle strobe; compare and latch demand this cycle.
- `temp`  in  WIDTH  current temperature.
- `low_thresh`  in  WIDTH  heat when `temp < low_thresh`.
- `high_thresh`  in  WIDTH  cool when `temp > high_thresh`.
- `heat_out`  out  1  heater enable.
- `cool_out`  out  1  cooler enable.
- `state`  out  2  FSM state: IDLE=0, HEAT=1, COOL=2, LOCK=3.
- `cfg_err`  out  1  the last sample saw `low_thresh > high_thresh`.
- `force_off`  in  1  present only with `HVAC_SEQ_FORCE_EN`.

## Operation
- **Demand latch.** On a cycle with `sample`=1, register the following:
  - `heat_dem` = `temp < low_thresh`
  - `cool_dem` = `temp > high_thresh`
  - `cfg_err` = `low_thresh > high_thresh`
- If `cfg_err` is computed as 1, both demands latch 0.
- Demands hold until the next `sample`.
- Equality with a threshold produces no demand.
- Outputs are Moore-decoded from the state register: `heat_out` = (state==HEAT), `cool_out` = (state==COOL).
- **IDLE**
  - If `heat_dem` → HEAT.
  - Else if `cool_dem` → COOL.
  - Else stay.
- **HEAT / COOL**
  - The dwell timer clears on entry and counts cycles in the state.
  - Exit to LOCK only when the dwell is at least MIN_ON cycles and the own demand is 0.
  - The opposite demand alone does not force an exit before MIN_ON.
- **LOCK**
  - Both outputs are 0.
  - The state lasts exactly MIN_OFF cycles, then → IDLE, regardless of demand.
  - Demand latching continues during LOCK.
- No transition exists HEAT→COOL or COOL→HEAT except via LOCK and IDLE.
- **Reset** (including mid-operation): on the cycle after `rst` high:
  - state=IDLE, `heat_out`=0, `cool_out`=0.
  - `heat_dem`=`cool_dem`=0, `cfg_err`=0, timer=0.
  - No lockout is applied after reset.
- `sample` during `rst` is ignored.
- The timer saturates and never wraps.

## Timing
- `sample` high in cycle N → demand registered at the end of N → FSM transitions at the end of N+1 → actuator output high from cycle N+2, provided the FSM is in IDLE.
- Minimum actuator pulse: exactly MIN_ON cycles when demand has already dropped.
- Demand removal sampled in cycle M after the minimum has elapsed → output low from cycle M+2.
- Minimum gap from one actuator falling to any actuator rising: MIN_OFF+1 cycles (LOCK, then one IDLE cycle).
- `cfg_err` updates one cycle after the sampling cycle.
- A `cfg_err` raised while in HEAT/COOL clears demand; the exit still honours MIN_ON.

## Configuration
- `HVAC_SEQ_FORCE_EN` defined:
  - Adds the `force_off` input.
  - While `force_off`=1, HEAT/COOL go to LOCK on the next edge, bypassing MIN_ON.
  - IDLE stays IDLE, regardless of demand.
  - LOCK still runs its full MIN_OFF.
  - `rst` has priority over `force_off`.
- Not defined: the port is absent and the FSM behaves as if `force_off`=0.

## Test plan
All tests use MIN_ON=8, MIN_OFF=8, low=20, high=26.
- **Reset:** `rst`=1 for 2 cycles, with `temp`=18 and `sample`=1 → `heat_out`=0, `cool_out`=0, `state`=0, `cfg_err`=0. Reassert `rst` while in HEAT → IDLE and outputs 0 the next cycle.
- **Heating cycle:** sample `temp`=18 at cycle 10 → `heat_out`=1 cycles 12–19. Sample `temp`=24 at cycle 13 → `heat_out`=0 at cycle 20, `state`=3 for cycles 20–27, IDLE at 28.
- **Changeover:** while heating, sample `temp`=30 → `heat_out` still high for the full 8 cycles, then LOCK for 8 cycles, one IDLE cycle, then `cool_out`=1. The two outputs are never high together.
- **Boundaries:** sample `temp`=20, then sample `temp`=26 → no demand, `state` stays 0. Sample `temp`=19 → HEAT.
- **Config error:** low=30, high=25, sample `temp`=10 → `cfg_err`=1 next cycle, no heat. Restore low=20 and sample again → `cfg_err`=0.
- **Forced off (`HVAC_SEQ_FORCE_EN`):** `force_off`=1 in the 3rd HEAT cycle → `heat_out`=0 next cycle, then LOCK for 8 cycles. Hold `force_off` with `temp`=10 → remains in IDLE.

Source files
------------

// File: rtl/hvac_seq.sv
// Heater/cooler sequencer: latches threshold demand on a strobe and runs a
// IDLE/HEAT/COOL/LOCK FSM with minimum on-time and lockout. Optional HVAC_SEQ_FORCE_EN adds force_off.
module hvac_seq #(
    parameter int WIDTH   = 16,
    parameter int CNT_W   = 8,
    parameter int MIN_ON  = 8,
    parameter int MIN_OFF = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample,
    input  logic [WIDTH-1:0] temp,
    input  logic [WIDTH-1:0] low_thresh,
    input  logic [WIDTH-1:0] high_thresh,
`ifdef HVAC_SEQ_FORCE_EN
    input  logic             force_off,
`endif
    output logic             heat_out,
    output logic             cool_out,
    output logic [1:0]       state,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAT = 2'd1,
        COOL = 2'd2,
        LOCK = 2'd3
    } state_t;

    // Dwell reads 0 on the first cycle of a state, so the last allowed value is MIN-1.
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             heat_dem_q, heat_dem_d;
    logic             cool_dem_q, cool_dem_d;
    logic             cfg_err_q, cfg_err_d;
    logic             force_int;

`ifdef HVAC_SEQ_FORCE_EN
    assign force_int = force_off;
`else
    assign force_int = 1'b0;
`endif

    always_comb begin
        heat_dem_d = heat_dem_q;
        cool_dem_d = cool_dem_q;
        cfg_err_d  = cfg_err_q;
        if (sample) begin
            cfg_err_d  = low_thresh > high_thresh;
            heat_dem_d = !cfg_err_d && (temp < low_thresh);
            cool_dem_d = !cfg_err_d && (temp > high_thresh);
        end
    end

    always_comb begin
        state_d = state_q;
        dwell_d = (dwell_q == CNT_MAX) ? dwell_q : dwell_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (!force_int) begin
                    if (heat_dem_q)      state_d = HEAT;
                    else if (cool_dem_q) state_d = COOL;
                end
            end
            HEAT: if (force_int || (dwell_q >= ON_LAST && !heat_dem_q)) state_d = LOCK;
            COOL: if (force_int || (dwell_q >= ON_LAST && !cool_dem_q)) state_d = LOCK;
            LOCK: if (dwell_q >= OFF_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) dwell_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dwell_q    <= '0;
            heat_dem_q <= 1'b0;
            cool_dem_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            heat_dem_q <= heat_dem_d;
            cool_dem_q <= cool_dem_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign state    = state_q;
    assign heat_out = (state_q == HEAT);
    assign cool_out = (state_q == COOL);
    assign cfg_err  = cfg_err_q;

endmodule
